duc_frame_packer: RTL

- Sits directly downstream of the DUC output FIFO on axis_clk.
- Consumes the DUC AXI-stream of 32-bit {I[15:0],Q[15:0]} samples, framed by tlast every 256 beats.
- Stores each frame whole (store-and-forward), then emits it behind a 2-word header (sync word plus sequence/length/status) to the DMA/transport AXI-stream master.
- Also truncates overlength frames and keeps frame and drop counters for local-bus status.

---
 rtl/dfp_pkg.sv | 30 +++
 rtl/dfp_sdp_ram.sv | 34 +++
 rtl/duc_frame_packer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dfp_pkg.sv
// Shared types and constants for the DUC frame packer: FSM states, the sync
// word and the bit layout of header word 1.
package dfp_pkg;

  typedef enum logic [2:0] {
    S_FILL,
    S_FLUSH,
    S_HDR0,
    S_HDR1,
    S_DATA
  } state_t;

  localparam logic [31:0] SYNC_WORD = 32'hA5A5_5A5A;

  localparam int TRUNC_BIT = 31;
  localparam int SEQ_MSB   = 30;
  localparam int SEQ_LSB   = 16;
  localparam int LEN_MSB   = 15;

  // Header word 1: {trunc, seq[14:0], len[15:0]}
  function automatic logic [31:0] make_header(logic trunc, logic [14:0] seq, logic [15:0] len);
    logic [31:0] h;
    h                    = '0;
    h[TRUNC_BIT]         = trunc;
    h[SEQ_MSB:SEQ_LSB]   = seq;
    h[LEN_MSB:0]         = len;
    return h;
  endfunction

endpackage

// File: rtl/dfp_sdp_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port
// with read latency 1. The read register holds while re_i is low.
module dfp_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/duc_frame_packer.sv
// Store-and-forward packer: buffers one DUC frame, then emits it behind a
// sync word and a {trunc, seq, len} header on the transport stream.
module duc_frame_packer
  import dfp_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                MAX_BEATS = 256,
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_WORD = dfp_pkg::SYNC_WORD
) (
  input  logic              axis_clk,
  input  logic              rst,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  // Handshake: a beat moves on either stream only in a cycle where valid and
  // ready are both high at the rising edge; a presented master word holds
  // tdata/tlast and keeps tvalid high until it is accepted.

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     rd_addr_q, rd_addr_d;
  logic [15:0]         len_q, len_d;
  logic                trunc_q, trunc_d;
  logic [14:0]         seq_q, seq_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  logic                in_fire;
  logic                out_fire;
  logic                ram_we;
  logic                ram_re;
  logic [DATA_W-1:0]   ram_rdata;

  assign s_axis_tready = !rst && ((state_q == S_FILL) || (state_q == S_FLUSH));
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign out_fire      = out_valid_q && m_axis_tready;
  assign ram_we        = in_fire && (state_q == S_FILL);

  dfp_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_BEATS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (axis_clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_axis_tdata),
    .re_i    (ram_re),
    .raddr_i (rd_addr_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge axis_clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      wr_ptr_q    <= '0;
      rd_addr_q   <= '0;
      len_q       <= '0;
      trunc_q     <= 1'b0;
      seq_q       <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_addr_q   <= rd_addr_d;
      len_q       <= len_d;
      trunc_q     <= trunc_d;
      seq_q       <= seq_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    len_d       = len_q;
    trunc_d     = trunc_q;
    seq_d       = seq_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    case (state_q)
      S_FILL: begin
        if (in_fire) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (s_axis_tlast) begin
            len_d   = 16'(wr_ptr_q) + 16'd1;
            trunc_d = 1'b0;
            state_d = S_HDR0;
          end else if (wr_ptr_q == ADDR_W'(MAX_BEATS - 1)) begin
            len_d   = 16'(MAX_BEATS);
            trunc_d = 1'b1;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (in_fire && s_axis_tlast) begin
          state_d    = S_HDR0;
          drop_cnt_d = (drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        end
      end
      S_HDR0: begin
        if (out_fire) state_d = S_HDR1;
      end
      S_HDR1: begin
        if (out_fire) state_d = S_DATA;
      end
      S_DATA: begin
        if (out_fire && out_last_q) begin
          state_d     = S_FILL;
          seq_d       = seq_q + 15'd1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          wr_ptr_d    = '0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // rd_addr_q runs one word ahead of the output register so the RAM read
  // register always holds the next data word when the current one is taken.
  always_comb begin
    out_valid_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    rd_addr_d   = rd_addr_q;
    ram_re      = 1'b0;
    case (state_q)
      S_FILL, S_FLUSH: begin
        if (state_d == S_HDR0) begin
          out_data_d = SYNC_WORD;
          out_last_d = 1'b0;
        end
      end
      S_HDR0: begin
        ram_re = 1'b1;
        if (out_fire) begin
          out_data_d = make_header(trunc_q, seq_q, len_q);
          rd_addr_d  = rd_addr_q + 1'b1;
        end
      end
      S_HDR1, S_DATA: begin
        if (out_fire) begin
          if (out_last_q) begin
            out_last_d = 1'b0;
            rd_addr_d  = '0;
          end else begin
            ram_re     = 1'b1;
            out_data_d = ram_rdata;
            out_last_d = (rd_addr_q == len_q[ADDR_W:0]);
            rd_addr_d  = rd_addr_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign busy          = !((state_q == S_FILL) && (wr_ptr_q == '0));

endmodule
